// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Round-robin arbiter and access sequencer between the instruction-fetch
// port and the load/store port of the core, in front of a shared
// single-port memory with one-cycle registered read latency and
// write-first behaviour. Byte addresses become word indices; sub-word
// stores are done as read-modify-write because the memory has no byte
// enables.
//
// Ports
//   i_Clock, i_Reset                 clock, async active-high reset
//   i_FetchValid / i_FetchAddress    fetch read request
//   o_FetchReady                     fetch request accepted this cycle
//   o_FetchRespValid / o_FetchData   fetched word, one-cycle pulse
//   i_DataValid / i_DataWrite        load/store request, 1 = store
//   i_DataByteEnable / i_DataAddress / i_DataWData  store mask, address, data
//   o_DataReady                      data request accepted this cycle
//   o_DataRespValid / o_DataRData    load data or store ack (word as written)
//   o_MemWriteEnable / o_MemAddress / o_MemDataIn   memory request
//   i_MemDataOut                     memory registered read data
module memory_arbiter #(
  parameter int ADDR_BITS = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_FetchValid,
  input  logic [31:0] i_FetchAddress,
  output logic        o_FetchReady,
  output logic        o_FetchRespValid,
  output logic [31:0] o_FetchData,
  input  logic        i_DataValid,
  input  logic        i_DataWrite,
  input  logic [3:0]  i_DataByteEnable,
  input  logic [31:0] i_DataAddress,
  input  logic [31:0] i_DataWData,
  output logic        o_DataReady,
  output logic        o_DataRespValid,
  output logic [31:0] o_DataRData,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  input  logic [31:0] i_MemDataOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_MERGE
  } state_t;

  state_t               state_q, state_d;
  logic                 last_data_q;   // 1 = data port won the last grant
  logic                 owner_data_q;  // owner of the access completing in RESP
  logic [ADDR_BITS-1:0] rmw_index_q;
  logic [31:0]          rmw_data_q;
  logic [3:0]           rmw_mask_q;

  logic                 grant_fetch, grant_data;
  logic                 data_full, data_partial;
  logic [ADDR_BITS-1:0] fetch_index, data_index, mem_index;
  logic [31:0]          merged;
  logic                 resp_active;

  // Byte offsets and index bits above the memory size are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_FetchAddress[31:ADDR_BITS+2], i_FetchAddress[1:0],
                              i_DataAddress[31:ADDR_BITS+2], i_DataAddress[1:0]};

  assign fetch_index  = i_FetchAddress[ADDR_BITS+1:2];
  assign data_index   = i_DataAddress[ADDR_BITS+1:2];
  // An all-zero mask falls through as a plain read and is acknowledged like one.
  assign data_full    = i_DataWrite && (i_DataByteEnable == 4'b1111);
  assign data_partial = i_DataWrite && (i_DataByteEnable != 4'b1111)
                                    && (i_DataByteEnable != 4'b0000);

  // Enabled lanes from the latched store data, the rest from the word read
  // in the grant cycle.
  always_comb begin
    merged = i_MemDataOut;
    for (int k = 0; k < 4; k++) begin
      if (rmw_mask_q[k]) merged[8*k +: 8] = rmw_data_q[8*k +: 8];
    end
  end

  // Grant, memory request and next state. Everything is forced to zero while
  // reset is high so the memory never sees a stray write.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    grant_fetch      = 1'b0;
    grant_data       = 1'b0;
    state_d          = S_IDLE;
    o_MemWriteEnable = 1'b0;
    mem_index        = '0;
    o_MemDataIn      = '0;
    if (!i_Reset) begin
      if (state_q == S_MERGE) begin
        o_MemWriteEnable = 1'b1;
        mem_index        = rmw_index_q;
        o_MemDataIn      = merged;
        state_d          = S_RESP;
      end else begin
        // On conflict the port that did not win last time is served.
        if (i_DataValid && (!i_FetchValid || !last_data_q)) grant_data = 1'b1;
        else if (i_FetchValid)                               grant_fetch = 1'b1;

        if (grant_data) begin
          mem_index = data_index;
          state_d   = data_partial ? S_MERGE : S_RESP;
          if (data_full) begin
            o_MemWriteEnable = 1'b1;
            o_MemDataIn      = i_DataWData;
          end
        end else if (grant_fetch) begin
          mem_index = fetch_index;
          state_d   = S_RESP;
        end
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      last_data_q  <= 1'b0;
      owner_data_q <= 1'b0;
      // NOTE: the RMW latches are reset too, so a half-finished merge can
      // never leak stale data into a later access.
      rmw_index_q  <= '0;
      rmw_data_q   <= '0;
      rmw_mask_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if (grant_data || grant_fetch) begin
        last_data_q  <= grant_data;
        owner_data_q <= grant_data;
      end
      if (grant_data && data_partial) begin
        rmw_index_q <= data_index;
        rmw_data_q  <= i_DataWData;
        rmw_mask_q  <= i_DataByteEnable;
      end
    end
  end

  assign o_MemAddress = 32'(mem_index);
  assign o_FetchReady = grant_fetch;
  assign o_DataReady  = grant_data;

  // Memory is write-first, so a store's response word is the word written.
  assign resp_active      = (state_q == S_RESP) && !i_Reset;
  assign o_FetchRespValid = resp_active && !owner_data_q;
  assign o_DataRespValid  = resp_active && owner_data_q;
  assign o_FetchData      = o_FetchRespValid ? i_MemDataOut : '0;
  assign o_DataRData      = o_DataRespValid  ? i_MemDataOut : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_FetchValid = 1'b0;
  logic [31:0] i_FetchAddress = '0;
  logic        o_FetchReady;
  logic        o_FetchRespValid;
  logic [31:0] o_FetchData;
  logic        i_DataValid = 1'b0;
  logic        i_DataWrite = 1'b0;
  logic [3:0]  i_DataByteEnable = '0;
  logic [31:0] i_DataAddress = '0;
  logic [31:0] i_DataWData = '0;
  logic        o_DataReady;
  logic        o_DataRespValid;
  logic [31:0] o_DataRData;
  logic        o_MemWriteEnable;
  logic [31:0] o_MemAddress;
  logic [31:0] o_MemDataIn;
  logic [31:0] i_MemDataOut;

  always #5 i_Clock = ~i_Clock;

  memory_arbiter #(.ADDR_BITS(16)) dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_FetchValid     (i_FetchValid),
    .i_FetchAddress   (i_FetchAddress),
    .o_FetchReady     (o_FetchReady),
    .o_FetchRespValid (o_FetchRespValid),
    .o_FetchData      (o_FetchData),
    .i_DataValid      (i_DataValid),
    .i_DataWrite      (i_DataWrite),
    .i_DataByteEnable (i_DataByteEnable),
    .i_DataAddress    (i_DataAddress),
    .i_DataWData      (i_DataWData),
    .o_DataReady      (o_DataReady),
    .o_DataRespValid  (o_DataRespValid),
    .o_DataRData      (o_DataRData),
    .o_MemWriteEnable (o_MemWriteEnable),
    .o_MemAddress     (o_MemAddress),
    .o_MemDataIn      (o_MemDataIn),
    .i_MemDataOut     (i_MemDataOut)
  );

  // Single-port write-first memory, one-cycle registered read.
  logic [31:0] mem [0:255];
  always @(posedge i_Clock) begin
    if (o_MemWriteEnable) begin
      mem[o_MemAddress[7:0]] <= o_MemDataIn;
      i_MemDataOut           <= o_MemDataIn;
    end else begin
      i_MemDataOut <= mem[o_MemAddress[7:0]];
    end
  end

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];

  // Monitor: pops the expected response whenever the DUT presents one.
  exp_t mon_e;
  always @(negedge i_Clock) begin
    if (o_FetchRespValid) begin
      if (fq.size() == 0) check("fetch_resp_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = fq.pop_front();
        check("fetch_rdata", o_FetchData, mon_e.data);
        check("fetch_resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (o_DataRespValid) begin
      if (dq.size() == 0) check("data_resp_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = dq.pop_front();
        check("data_rdata", o_DataRData, mon_e.data);
        check("data_resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic idle(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic await_fetch(input logic [31:0] exp);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_Clock);
      if (o_FetchReady) begin
        got    = 1'b1;
        e.data = exp;
        e.cyc  = cyc + 1;
        fq.push_back(e);
      end
    end
    if (!got) check("fetch_accept_timeout", 32'd0, 32'd1);
    @(posedge i_Clock);
    #1;
    i_FetchValid = 1'b0;
  endtask

  // lat = 0: accepted but no response expected.
  task automatic await_data(input logic [31:0] exp, input int lat);
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_Clock);
      if (o_DataReady) begin
        got = 1'b1;
        if (lat > 0) begin
          e.data = exp;
          e.cyc  = cyc + lat;
          dq.push_back(e);
        end
      end
    end
    if (!got) check("data_accept_timeout", 32'd0, 32'd1);
    @(posedge i_Clock);
    #1;
    i_DataValid = 1'b0;
  endtask

  task automatic issue_fetch(input logic [31:0] addr, input logic [31:0] exp);
    i_FetchValid   = 1'b1;
    i_FetchAddress = addr;
    await_fetch(exp);
  endtask

  task automatic issue_data(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp, input int lat);
    i_DataValid      = 1'b1;
    i_DataWrite      = wr;
    i_DataByteEnable = be;
    i_DataAddress    = addr;
    i_DataWData      = wdata;
    await_data(exp, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readys"},     {30'd0, o_FetchReady, o_DataReady}, 32'd0);
    check({tag, "_respvalids"}, {30'd0, o_FetchRespValid, o_DataRespValid}, 32'd0);
    check({tag, "_mem_we"},     {31'd0, o_MemWriteEnable}, 32'd0);
    check({tag, "_mem_addr"},   o_MemAddress, 32'd0);
    check({tag, "_mem_din"},    o_MemDataIn, 32'd0);
    check({tag, "_fetch_data"}, o_FetchData, 32'd0);
    check({tag, "_data_rdata"}, o_DataRData, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, outputs all zero.
    @(negedge i_Clock);
    check_all_zero("por");
    repeat (2) @(posedge i_Clock);
    #1 i_Reset = 1'b0;

    // Preload via full-word stores: ack one cycle later with the word written.
    issue_data(1'b1, 4'b1111, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    issue_data(1'b1, 4'b1111, 32'h80, 32'h0BADF00D, 32'h0BADF00D, 1);

    // Single fetch of byte address 0x40 -> word 0x10.
    issue_fetch(32'h40, 32'hDEADBEEF);
    idle(2);

    // Mid-simulation reset with no clock edge: outputs drop at once.
    i_FetchValid   = 1'b1;
    i_FetchAddress = 32'h40;
    #1;
    check("pre_reset_fetch_ready", {31'd0, o_FetchReady}, 32'd1);
    check("pre_reset_mem_addr", o_MemAddress, 32'h10);
    i_Reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    i_FetchValid = 1'b0;
    idle(2);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    check("post_reset_idle", {29'd0, o_FetchRespValid, o_DataRespValid, o_MemWriteEnable}, 32'd0);
    idle(1);

    // Conflict right after reset: data, fetch, data, fetch; one ready per cycle.
    i_FetchValid     = 1'b1;
    i_FetchAddress   = 32'h40;
    i_DataValid      = 1'b1;
    i_DataWrite      = 1'b0;
    i_DataByteEnable = 4'b0000;
    i_DataAddress    = 32'h80;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      @(negedge i_Clock);
      check("conflict_readys", {30'd0, o_DataReady, o_FetchReady}, (k % 2 == 0) ? 32'd2 : 32'd1);
      e.cyc = cyc + 1;
      if (o_DataReady)  begin e.data = 32'h0BADF00D; dq.push_back(e); end
      if (o_FetchReady) begin e.data = 32'hDEADBEEF; fq.push_back(e); end
    end
    @(posedge i_Clock);
    #1;
    i_FetchValid = 1'b0;
    i_DataValid  = 1'b0;
    idle(1);

    // Partial store: 0x11223344, mask 0101 with 0xAABBCCDD -> 0x11BB33DD, ack at N+2.
    issue_data(1'b1, 4'b1111, 32'h40, 32'h11223344, 32'h11223344, 1);
    issue_data(1'b1, 4'b0101, 32'h40, 32'hAABBCCDD, 32'h11BB33DD, 2);
    // Now in the merge cycle: both ports requesting, neither may be accepted.
    i_FetchValid     = 1'b1;
    i_FetchAddress   = 32'h40;
    i_DataValid      = 1'b1;
    i_DataWrite      = 1'b0;
    i_DataByteEnable = 4'b0000;
    i_DataAddress    = 32'h80;
    @(negedge i_Clock);
    check("merge_no_ready", {30'd0, o_DataReady, o_FetchReady}, 32'd0);
    // Data won last, so fetch goes first, then data back-to-back from RESP.
    await_fetch(32'h11BB33DD);
    await_data(32'h0BADF00D, 1);
    issue_data(1'b0, 4'b0000, 32'h40, 32'h0, 32'h11BB33DD, 1);

    // Zero mask acts as a read: ack with the current word, no write.
    issue_data(1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, 32'h11BB33DD, 1);
    issue_data(1'b0, 4'b0000, 32'h40, 32'h0, 32'h11BB33DD, 1);

    // Full-word store then fetch.
    issue_data(1'b1, 4'b1111, 32'h80, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    issue_fetch(32'h80, 32'hCAFEF00D);

    // Reset in the merge cycle: no write, no ack, word unchanged.
    issue_data(1'b1, 4'b0011, 32'h40, 32'h99999999, 32'h0, 0);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    check("rmw_reset_no_write", {31'd0, o_MemWriteEnable}, 32'd0);
    @(posedge i_Clock);
    #1 i_Reset = 1'b0;
    @(negedge i_Clock);
    check("rmw_reset_idle", {29'd0, o_FetchRespValid, o_DataRespValid, o_MemWriteEnable}, 32'd0);
    idle(1);
    issue_data(1'b0, 4'b0000, 32'h40, 32'h0, 32'h11BB33DD, 1);

    // Byte-offset bits are ignored.
    issue_fetch(32'h83, 32'hCAFEF00D);
    issue_data(1'b0, 4'b0000, 32'h42, 32'h0, 32'h11BB33DD, 1);

    idle(3);
    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    check("data_queue_drained", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
